// File: rtl/vertex_rotator.sv
// vertex_rotator: rotates one vertex about Z, then Y, then X on a shared external CORDIC unit.
// Build option SKIP_ZERO_ANGLE_EN bypasses any rotation whose angle is zero.
module vertex_rotator #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] z_i,
  input  logic [DATA_W-1:0] angle_x_i,
  input  logic [DATA_W-1:0] angle_y_i,
  input  logic [DATA_W-1:0] angle_z_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] y_o,
  output logic [DATA_W-1:0] z_o,
  output logic              err_o,
  output logic              cordic_start_o,
  output logic [DATA_W-1:0] cordic_angle_o,
  output logic [DATA_W-1:0] cordic_x_o,
  output logic [DATA_W-1:0] cordic_y_o,
  input  logic [DATA_W-1:0] cordic_x_i,
  input  logic [DATA_W-1:0] cordic_y_i,
  input  logic              cordic_done_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_Z,
    S_WAIT_Z,
    S_ISSUE_Y,
    S_WAIT_Y,
    S_ISSUE_X,
    S_WAIT_X,
    S_OUT
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] ry_q, ry_d;
  logic [DATA_W-1:0] rz_q, rz_d;
  logic [DATA_W-1:0] orig_x_q, orig_x_d;
  logic [DATA_W-1:0] orig_y_q, orig_y_d;
  logic [DATA_W-1:0] orig_z_q, orig_z_d;
  logic [DATA_W-1:0] ang_x_q, ang_x_d;
  logic [DATA_W-1:0] ang_y_q, ang_y_d;
  logic [DATA_W-1:0] ang_z_q, ang_z_d;
  logic [7:0]        timer_q, timer_d;
  logic              err_q, err_d;
  logic              waiting;
  logic              timed_out;
  logic              skip_x, skip_y, skip_z;

`ifdef SKIP_ZERO_ANGLE_EN
  assign skip_z = (ang_z_q == '0);
  assign skip_y = (ang_y_q == '0);
  assign skip_x = (ang_x_q == '0);
`else
  assign skip_z = 1'b0;
  assign skip_y = 1'b0;
  assign skip_x = 1'b0;
`endif

  assign waiting   = (state_q == S_WAIT_Z) || (state_q == S_WAIT_Y) || (state_q == S_WAIT_X);
  assign timed_out = waiting && !cordic_done_i && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q     <= '0;
      ry_q     <= '0;
      rz_q     <= '0;
      orig_x_q <= '0;
      orig_y_q <= '0;
      orig_z_q <= '0;
      ang_x_q  <= '0;
      ang_y_q  <= '0;
      ang_z_q  <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      rz_q     <= rz_d;
      orig_x_q <= orig_x_d;
      orig_y_q <= orig_y_d;
      orig_z_q <= orig_z_d;
      ang_x_q  <= ang_x_d;
      ang_y_q  <= ang_y_d;
      ang_z_q  <= ang_z_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rx_d           = rx_q;
    ry_d           = ry_q;
    rz_d           = rz_q;
    orig_x_d       = orig_x_q;
    orig_y_d       = orig_y_q;
    orig_z_d       = orig_z_q;
    ang_x_d        = ang_x_q;
    ang_y_d        = ang_y_q;
    ang_z_d        = ang_z_q;
    timer_d        = timer_q;
    err_d          = err_q;
    ready_o        = 1'b0;
    valid_o        = 1'b0;
    cordic_start_o = 1'b0;
    cordic_angle_o = '0;
    cordic_x_o     = '0;
    cordic_y_o     = '0;

    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          rx_d     = x_i;
          ry_d     = y_i;
          rz_d     = z_i;
          orig_x_d = x_i;
          orig_y_d = y_i;
          orig_z_d = z_i;
          ang_x_d  = angle_x_i;
          ang_y_d  = angle_y_i;
          ang_z_d  = angle_z_i;
          err_d    = 1'b0;
          state_d  = S_ISSUE_Z;
        end
      end

      S_ISSUE_Z: begin
        cordic_angle_o = ang_z_q;
        cordic_x_o     = rx_q;
        cordic_y_o     = ry_q;
        timer_d        = '0;
        if (skip_z) begin
          state_d = S_ISSUE_Y;
        end else begin
          cordic_start_o = 1'b1;
          state_d        = S_WAIT_Z;
        end
      end

      S_WAIT_Z: begin
        cordic_angle_o = ang_z_q;
        cordic_x_o     = rx_q;
        cordic_y_o     = ry_q;
        if (cordic_done_i) begin
          rx_d    = cordic_x_i;
          ry_d    = cordic_y_i;
          state_d = S_ISSUE_Y;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_ISSUE_Y: begin
        cordic_angle_o = ang_y_q;
        cordic_x_o     = rz_q;
        cordic_y_o     = rx_q;
        timer_d        = '0;
        if (skip_y) begin
          state_d = S_ISSUE_X;
        end else begin
          cordic_start_o = 1'b1;
          state_d        = S_WAIT_Y;
        end
      end

      S_WAIT_Y: begin
        cordic_angle_o = ang_y_q;
        cordic_x_o     = rz_q;
        cordic_y_o     = rx_q;
        if (cordic_done_i) begin
          rz_d    = cordic_x_i;
          rx_d    = cordic_y_i;
          state_d = S_ISSUE_X;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_ISSUE_X: begin
        cordic_angle_o = ang_x_q;
        cordic_x_o     = ry_q;
        cordic_y_o     = rz_q;
        timer_d        = '0;
        if (skip_x) begin
          state_d = S_OUT;
        end else begin
          cordic_start_o = 1'b1;
          state_d        = S_WAIT_X;
        end
      end

      S_WAIT_X: begin
        cordic_angle_o = ang_x_q;
        cordic_x_o     = ry_q;
        cordic_y_o     = rz_q;
        if (cordic_done_i) begin
          ry_d    = cordic_x_i;
          rz_d    = cordic_y_i;
          state_d = S_OUT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_OUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An aborted vertex leaves unrotated, so the working pair is restored from the latched copy.
    if (timed_out) begin
      err_d   = 1'b1;
      rx_d    = orig_x_q;
      ry_d    = orig_y_q;
      rz_d    = orig_z_q;
      state_d = S_OUT;
    end
  end

  assign x_o   = (state_q == S_OUT) ? rx_q : '0;
  assign y_o   = (state_q == S_OUT) ? ry_q : '0;
  assign z_o   = (state_q == S_OUT) ? rz_q : '0;
  assign err_o = err_q;

endmodule

// File: tb/tb_vertex_rotator.sv
// Self-checking bench for vertex_rotator with a behavioural CORDIC model (Lc = 18 cycles).
// Honours SKIP_ZERO_ANGLE_EN when computing expected latency and start-pulse counts.
module tb_vertex_rotator;

  localparam int LC      = 18;
  localparam int TIMEOUT = 255;
  localparam int TOL     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] x_i = '0, y_i = '0, z_i = '0;
  logic [15:0] angle_x_i = '0, angle_y_i = '0, angle_z_i = '0;
  logic        ready_o, valid_o, err_o, cordic_start_o;
  logic [15:0] x_o, y_o, z_o;
  logic [15:0] cordic_angle_o, cordic_x_o, cordic_y_o;

  logic        cm_done = 1'b0;
  logic [15:0] cm_x = '0, cm_y = '0;
  int          cm_cnt = 0;
  bit          cm_busy = 1'b0;
  bit          cm_mute = 1'b0;
  int          cm_px = 0, cm_py = 0;
  int          start_cnt = 0;

  int total = 0;
  int bad = 0;

  vertex_rotator #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .x_i            (x_i),
    .y_i            (y_i),
    .z_i            (z_i),
    .angle_x_i      (angle_x_i),
    .angle_y_i      (angle_y_i),
    .angle_z_i      (angle_z_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .x_o            (x_o),
    .y_o            (y_o),
    .z_o            (z_o),
    .err_o          (err_o),
    .cordic_start_o (cordic_start_o),
    .cordic_angle_o (cordic_angle_o),
    .cordic_x_o     (cordic_x_o),
    .cordic_y_o     (cordic_y_o),
    .cordic_x_i     (cm_x),
    .cordic_y_i     (cm_y),
    .cordic_done_i  (cm_done)
  );

  always #5 clk = ~clk;

  function automatic real ang_rad(input int ang);
    return $itor(ang) * 6.283185307179586 / 65536.0;
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rot_a(input int a, input int b, input int ang);
    real t = ang_rad(ang);
    return rnd($itor(a) * $cos(t) - $itor(b) * $sin(t));
  endfunction

  function automatic int rot_b(input int a, input int b, input int ang);
    real t = ang_rad(ang);
    return rnd($itor(a) * $sin(t) + $itor(b) * $cos(t));
  endfunction

  // Ideal rotation Rx * Ry * Rz applied in real arithmetic, rounded only once at the end.
  function automatic void ref_rotate(input int x, input int y, input int z,
                                     input int ax, input int ay, input int az,
                                     output int ex, output int ey, output int ez);
    real px = x, py = y, pz = z, t, a, b;
    t = ang_rad(az); a = px * $cos(t) - py * $sin(t); b = px * $sin(t) + py * $cos(t); px = a; py = b;
    t = ang_rad(ay); a = pz * $cos(t) - px * $sin(t); b = pz * $sin(t) + px * $cos(t); pz = a; px = b;
    t = ang_rad(ax); a = py * $cos(t) - pz * $sin(t); b = py * $sin(t) + pz * $cos(t); py = a; pz = b;
    ex = rnd(px); ey = rnd(py); ez = rnd(pz);
  endfunction

  function automatic int axis_cost(input int ang);
`ifdef SKIP_ZERO_ANGLE_EN
    if (ang == 0) return 1;
`endif
    return 1 + LC;
  endfunction

  function automatic int axis_starts(input int ang);
`ifdef SKIP_ZERO_ANGLE_EN
    if (ang == 0) return 0;
`endif
    return 1;
  endfunction

  function automatic int exp_lat(input int ax, input int ay, input int az);
    return 1 + axis_cost(az) + axis_cost(ay) + axis_cost(ax);
  endfunction

  function automatic int exp_starts(input int ax, input int ay, input int az);
    return axis_starts(az) + axis_starts(ay) + axis_starts(ax);
  endfunction

  // Behavioural CORDIC: result appears as a one-cycle done pulse LC cycles after start.
  always @(posedge clk) begin
    cm_done <= 1'b0;
    if (cordic_start_o === 1'b1) begin
      cm_busy <= 1'b1;
      cm_cnt  <= LC - 1;
      cm_px   <= rot_a(int'($signed(cordic_x_o)), int'($signed(cordic_y_o)), int'($signed(cordic_angle_o)));
      cm_py   <= rot_b(int'($signed(cordic_x_o)), int'($signed(cordic_y_o)), int'($signed(cordic_angle_o)));
    end else if (cm_busy) begin
      if (cm_cnt == 1) begin
        cm_busy <= 1'b0;
        if (!cm_mute) begin
          cm_done <= 1'b1;
          cm_x    <= cm_px[15:0];
          cm_y    <= cm_py[15:0];
        end
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (cordic_start_o === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic run_vertex(input int vx, input int vy, input int vz,
                            input int ax, input int ay, input int az,
                            output int lat, output int gx, output int gy, output int gz,
                            output logic gerr, output int nstart);
    int  s0;
    bit  got;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: ready_o=%b required 1", ready_o);
    end
    x_i = vx[15:0]; y_i = vy[15:0]; z_i = vz[15:0];
    angle_x_i = ax[15:0]; angle_y_i = ay[15:0]; angle_z_i = az[15:0];
    valid_i = 1'b1;
    s0  = start_cnt;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 2000 && !got; n++) begin
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      if (valid_o === 1'b1) begin
        got = 1'b1;
        lat = n;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL out_valid_wait: valid_o not seen within 2000 cycles");
    end
    gx = int'($signed(x_o)); gy = int'($signed(y_o)); gz = int'($signed(z_o));
    gerr   = err_o;
    nstart = start_cnt - s0;
  endtask

  task automatic handshake();
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
    total++;
    if (err_o !== 1'b0 || cordic_start_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: err_o=%b start=%b required 0/0", err_o, cordic_start_o);
    end
    total++;
    if ({x_o, y_o, z_o} !== 48'd0) begin
      bad++;
      $display("FAIL reset_vertex: got %h %h %h required 0", x_o, y_o, z_o);
    end
    total++;
    if ({cordic_angle_o, cordic_x_o, cordic_y_o} !== 48'd0) begin
      bad++;
      $display("FAIL reset_cordic: got %h %h %h required 0", cordic_angle_o, cordic_x_o, cordic_y_o);
    end
  endtask

  task automatic test_rot_z90();
    int lat, gx, gy, gz, ns;
    logic ge;
    run_vertex(1000, 0, 0, 0, 0, 16'h4000, lat, gx, gy, gz, ge, ns);
    total++;
    if (iabs(gx) > TOL || iabs(gy - 1000) > TOL || iabs(gz) > TOL || ge !== 1'b0) begin
      bad++;
      $display("FAIL z90_result: got (%0d,%0d,%0d) err=%b required (0,1000,0) err=0", gx, gy, gz, ge);
    end
    total++;
    if (lat != exp_lat(0, 0, 16'h4000)) begin
      bad++;
      $display("FAIL z90_latency: got %0d required %0d", lat, exp_lat(0, 0, 16'h4000));
    end
    handshake();
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL z90_release: valid_o=%b ready_o=%b required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_rot_x90();
    int lat, gx, gy, gz, ns;
    logic ge;
    run_vertex(0, 0, 500, 16'h4000, 0, 0, lat, gx, gy, gz, ge, ns);
    total++;
    if (iabs(gx) > TOL || iabs(gy + 500) > TOL || iabs(gz) > TOL || ge !== 1'b0) begin
      bad++;
      $display("FAIL x90_result: got (%0d,%0d,%0d) err=%b required (0,-500,0) err=0", gx, gy, gz, ge);
    end
    total++;
    if (ns != exp_starts(16'h4000, 0, 0)) begin
      bad++;
      $display("FAIL x90_starts: got %0d required %0d", ns, exp_starts(16'h4000, 0, 0));
    end
    handshake();
  endtask

  task automatic test_timeout();
    int lat, gx, gy, gz, ns;
    logic ge;
    cm_mute = 1'b1;
    run_vertex(123, -456, 789, 16'h1111, 16'h2222, 16'h3333, lat, gx, gy, gz, ge, ns);
    cm_mute = 1'b0;
    total++;
    if (ge !== 1'b1 || gx != 123 || gy != -456 || gz != 789) begin
      bad++;
      $display("FAIL timeout_result: got (%0d,%0d,%0d) err=%b required (123,-456,789) err=1", gx, gy, gz, ge);
    end
    total++;
    if (lat <= TIMEOUT || lat > TIMEOUT + 3) begin
      bad++;
      $display("FAIL timeout_latency: got %0d required %0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 3);
    end
    handshake();
    total++;
    if (ready_o !== 1'b1 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: ready_o=%b err_o=%b required 1/1", ready_o, err_o);
    end
  endtask

  task automatic test_backpressure();
    int lat, gx, gy, gz, ns, ex, ey, ez;
    logic ge;
    run_vertex(300, -200, 100, 16'h0800, 16'h1800, 16'h2800, lat, gx, gy, gz, ge, ns);
    ref_rotate(300, -200, 100, 16'h0800, 16'h1800, 16'h2800, ex, ey, ez);
    total++;
    if (iabs(gx - ex) > TOL || iabs(gy - ey) > TOL || iabs(gz - ez) > TOL || ge !== 1'b0) begin
      bad++;
      $display("FAIL bp_result: got (%0d,%0d,%0d) err=%b required (%0d,%0d,%0d) err=0", gx, gy, gz, ge, ex, ey, ez);
    end
    for (int i = 0; i < 10; i++) begin
      valid_i = (i % 2 == 0);
      x_i = 16'($urandom);
      angle_z_i = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || int'($signed(x_o)) != gx ||
          int'($signed(y_o)) != gy || int'($signed(z_o)) != gz) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: valid_o=%b ready_o=%b (%0d,%0d,%0d) required 1/0 (%0d,%0d,%0d)",
                 i, valid_o, ready_o, $signed(x_o), $signed(y_o), $signed(z_o), gx, gy, gz);
      end
    end
    valid_i = 1'b0;
    handshake();
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: valid_o=%b ready_o=%b required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_zero_angles();
    int lat, gx, gy, gz, ns;
    logic ge;
    run_vertex(7, 8, 9, 0, 0, 0, lat, gx, gy, gz, ge, ns);
    total++;
    if (iabs(gx - 7) > TOL || iabs(gy - 8) > TOL || iabs(gz - 9) > TOL || ge !== 1'b0) begin
      bad++;
      $display("FAIL zero_result: got (%0d,%0d,%0d) err=%b required (7,8,9) err=0", gx, gy, gz, ge);
    end
    total++;
    if (lat != exp_lat(0, 0, 0) || ns != exp_starts(0, 0, 0)) begin
      bad++;
      $display("FAIL zero_timing: latency %0d starts %0d required %0d and %0d",
               lat, ns, exp_lat(0, 0, 0), exp_starts(0, 0, 0));
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int   s0;
    bit   reached;
    logic ok;
    @(negedge clk);
    x_i = 16'd100; y_i = 16'd200; z_i = 16'd300;
    angle_x_i = 16'h1000; angle_y_i = 16'h1000; angle_z_i = 16'h1000;
    valid_i = 1'b1;
    s0 = start_cnt;
    reached = 1'b0;
    for (int n = 0; n < 200 && !reached; n++) begin
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      if (start_cnt - s0 == 2) reached = 1'b1;
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL rstmid_reach: second start pulse not seen within 200 cycles");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0 || cordic_start_o !== 1'b0 ||
          {x_o, y_o, z_o, cordic_angle_o, cordic_x_o, cordic_y_o} !== 96'd0)
        ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_idle: outputs left idle state after reset (ready_o=%b valid_o=%b)", ready_o, valid_o);
    end
  endtask

  task automatic test_random();
    int lat, gx, gy, gz, ns, ex, ey, ez, vx, vy, vz, ax, ay, az;
    logic ge;
    for (int i = 0; i < 6; i++) begin
      vx = int'($urandom_range(16000, 0)) - 8000;
      vy = int'($urandom_range(16000, 0)) - 8000;
      vz = int'($urandom_range(16000, 0)) - 8000;
      ax = int'($urandom_range(65535, 0));
      ay = (i == 2) ? 0 : int'($urandom_range(65535, 0));
      az = int'($urandom_range(65535, 0));
      run_vertex(vx, vy, vz, ax, ay, az, lat, gx, gy, gz, ge, ns);
      ref_rotate(vx, vy, vz, ax, ay, az, ex, ey, ez);
      total++;
      if (iabs(gx - ex) > TOL || iabs(gy - ey) > TOL || iabs(gz - ez) > TOL || ge !== 1'b0) begin
        bad++;
        $display("FAIL rand_result %0d: got (%0d,%0d,%0d) err=%b required (%0d,%0d,%0d) err=0",
                 i, gx, gy, gz, ge, ex, ey, ez);
      end
      total++;
      if (lat != exp_lat(ax, ay, az) || ns != exp_starts(ax, ay, az)) begin
        bad++;
        $display("FAIL rand_timing %0d: latency %0d starts %0d required %0d and %0d",
                 i, lat, ns, exp_lat(ax, ay, az), exp_starts(ax, ay, az));
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_rot_z90();
    test_rot_x90();
    test_timeout();
    test_random();
    test_backpressure();
    test_zero_angles();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
